// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the packed-BCD counter path.
package bcd_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
   localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

   // A nibble is a legal BCD digit when it lies in 0..9.
   function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
      return digit <= BCD_NINE;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the increment/decrement chain. Purely combinational;
// the carry/borrow out only asserts when this digit is enabled and rolls over.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic             enable,
   input  logic             down,
   output logic [BCD_W-1:0] next_digit,
   output logic             carry
);

   // 4-bit per-digit step with the roll-over flag kept separate from the digit.
   always_comb begin
      next_digit = digit;
      carry      = 1'b0;
      if (enable) begin
         if (down) begin
            if (digit == BCD_ZERO) begin
               next_digit = BCD_NINE;
               carry      = 1'b1;
            end else begin
               next_digit = digit - 4'd1;
            end
         end else begin
            if (digit == BCD_NINE) begin
               next_digit = BCD_ZERO;
               carry      = 1'b1;
            end else begin
               next_digit = digit + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_counter.sv
// N-digit packed-BCD up/down counter with clear, load (invalid digits
// forced to 0), and wrap or saturate behaviour at the bounds.
module bcd_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*DIGITS-1:0]     load_value,
   input  logic                    step,
   input  logic                    down,
   output logic [4*DIGITS-1:0]     count,
   output logic                    wrap,
   output logic                    load_err,
   output logic                    at_zero,
   output logic                    at_max
);

   logic [DIGITS-1:0][BCD_W-1:0] cnt_q;
   logic [DIGITS-1:0][BCD_W-1:0] step_d;
   logic [DIGITS-1:0][BCD_W-1:0] load_d;
   logic [DIGITS:0]              en;
   logic [DIGITS-1:0]            bad;
   logic [DIGITS-1:0]            nine;
   logic                         ovf;

   // Digit 0 is enabled by step; each higher digit by the roll-over of the one below.
   assign en[0] = step;

   genvar k;
   generate
      for (k = 0; k < DIGITS; k++) begin : g_digit
         bcd_digit_step u_digit (
            .digit      (cnt_q[k]),
            .enable     (en[k]),
            .down       (down),
            .next_digit (step_d[k]),
            .carry      (en[k+1])
         );
         assign bad[k]    = !bcd_valid(load_value[k*BCD_W +: BCD_W]);
         assign load_d[k] = bad[k] ? BCD_ZERO : load_value[k*BCD_W +: BCD_W];
         assign nine[k]   = (cnt_q[k] == BCD_NINE);
      end
   endgenerate

   // Roll-over out of the top digit means the whole count crossed a bound.
   assign ovf = en[DIGITS];

   // Count register and one-cycle pulse flags; clear > load > step > hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (clear) begin
         cnt_q    <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         cnt_q    <= load_d;
         wrap     <= 1'b0;
         load_err <= |bad;
      end else if (step) begin
         if (!(SATURATE && ovf)) cnt_q <= step_d;
         wrap     <= ovf && !SATURATE;
         load_err <= 1'b0;
      end else begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end
   end

   assign count   = cnt_q;
   assign at_zero = (cnt_q == '0);
   assign at_max  = &nine;

endmodule
